uart_rx_frame: RTL
==================

// Module: uart_rx_frame
// PURPOSE
//  Oversampling UART receive framer. Recovers 8N1-style serial frames from the rx pin using the 16x s_tick from the baud timer.
//  Emits one parallel word per frame with a single-cycle rx_done_tick. That tick is the write strobe of the rx FIFO.
//  Adds rx-pin synchronisation, start-bit glitch rejection, optional parity and framing/parity error flags.
// PARAMETERS
//  DBIT       8   data bits per frame, LSB first, legal 5..9
//  SB_TICK    16  s_ticks spent in stop bit (16=1, 24=1.5, 32=2 stop bits)
//  PARITY_EN  0   1: one parity bit follows data
//  PARITY_ODD 0   1: odd parity, 0: even (ignored when PARITY_EN=0)
// PORTS
//  clk          in   1     system clock
//  reset        in   1     synchronous, active-high reset
//  s_tick       in   1     1-cycle pulse at 16x baud rate
//  rx           in   1     asynchronous serial input, idle high
//  rx_done_tick out  1     1-cycle pulse: rx_dout/flags valid for new frame
//  rx_dout      out  DBIT  received word, held until next rx_done_tick
//  frame_err    out  1     stop bit sampled 0; updated with rx_done_tick
//  parity_err   out  1     parity mismatch; updated with rx_done_tick, 0 if !PARITY_EN
//  busy         out  1     1 while state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, s/n counters=0, shift reg=0.
//    rx_dout=0, rx_done_tick=0, frame_err=0, parity_err=0, busy=0.
//    Synchroniser flops reset to 1. Reset mid-frame aborts the frame with no done tick.
//  - rx passes a 2-flop synchroniser (rx_s). A third flop (rx_q) gives edge detection. All sampling uses rx_s.
//  - s counter is 5 bits and advances only on s_tick. n counter counts data bits.
//  - IDLE: on falling edge (rx_q=1, rx_s=0) -> START, s=0.
//    A level-low rx (break) never re-triggers; a high must be seen first.
//  - START: on s_tick with s==7 (mid start bit):
//    - rx_s==0 -> DATA, s=0, n=0.
//    - rx_s==1 -> IDLE (glitch, no output).
//    Otherwise s++ on each s_tick.
//  - DATA: on s_tick with s==15 -> shift {rx_s, sh[DBIT-1:1]}, s=0.
//    If n==DBIT-1 -> PARITY (PARITY_EN) or STOP; else n++.
//  - PARITY: on s_tick with s==15 -> latch p=rx_s, s=0 -> STOP.
//  - STOP: on s_tick with s==SB_TICK-1 -> IDLE. In that same cycle:
//    - rx_done_tick=1, rx_dout=sh, frame_err=~rx_s.
//    - parity_err = PARITY_EN & (^sh ^ p ^ PARITY_ODD).
//  - Frames with errors are still delivered (done tick asserted). The consumer decides what to do with them.
//  - Stop sampled mid-bit when SB_TICK=16 has 8 ticks of margin. Next start edge is accepted the cycle after IDLE is re-entered.
//  - Total latency from start-bit falling edge to done: 2 clk (sync) + ~(8+16*DBIT+16*PARITY_EN+SB_TICK) s_ticks.
//  - s_tick coincident with reset is ignored. s_tick while IDLE has no effect.
// STRUCTURE
//  - Shared package uart_pkg:
//    - state_t enum {IDLE, START, DATA, PARITY, STOP}.
//    - localparam OVERSAMPLE=16, MID_TICK=7.
//    uart_tx reuses these.
//  - One sub-module: sync_2ff (parameterised reset value, here 1) for the rx pin.
//  - Single always block for state/counters. Outputs are registered.
// TESTING (s_tick every clk unless stated; bit = 16 clk)
//  1. 8N1, send 0xA5 -> exactly one rx_done_tick, rx_dout=0xA5, frame_err=0, busy back to 0.
//  2. rx low for 4 ticks, then high -> no rx_done_tick, busy drops within 8 ticks, rx_dout unchanged.
//  3. Send 0x3C with stop bit=0, then hold rx low -> done with frame_err=1, rx_dout=0x3C.
//     No further done until rx high then a valid frame.
//  4. PARITY_EN=1 even: 0x07 + parity 1 -> parity_err=0. 0x07 + parity 0 -> parity_err=1.
//  5. reset pulse during bit 4 of DATA -> busy=0 next clk, no done. Then 0x55 received correctly.
//  6. s_tick every 3 clk, back-to-back 0x00, 0xFF with no idle gap -> two done pulses, correct data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// the parity helper used by the receive framer (the transmitter reuses these).
package uart_pkg;

    // Receiver/transmitter ticks per bit and the tick index of mid-start-bit
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Returns 1 when the received parity bit disagrees with the data word.
    // The word is zero-extended to 9 bits, which does not change its XOR.
    function automatic logic parity_mismatch(input logic [8:0] word,
                                             input logic       par_bit,
                                             input logic       odd);
        return (^word) ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs. The reset value is a
// parameter so idle-high lines (such as a UART rx pin) come out of reset
// at their idle level and do not fake an edge.
module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability chain: first flop may go metastable, second resolves it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= {WIDTH{RESET_VAL}};
            r_sync <= {WIDTH{RESET_VAL}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receive framer. Recovers start/data/[parity]/stop frames
// from the rx pin using a 16x s_tick and presents one word per frame.
//
// Output handshake: rx_done_tick is a valid-only strobe with no ready. It is
// high for exactly one clk per received frame; rx_dout, frame_err and
// parity_err change only in that cycle and hold until the next strobe. The
// consumer (normally the rx FIFO write port) must accept on that cycle.
// Frames with framing or parity errors are still delivered.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy,
    output state_t          o_dbg_state
);

    localparam logic [4:0] LAST_OS   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] MID_S     = 5'(MID_TICK);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [3:0] LAST_BIT  = 4'(DBIT - 1);
    localparam logic       PAR_EN    = (PARITY_EN != 0);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);

    logic            w_rx_s;
    logic            w_fall;
    logic            r_rx_q;

    state_t          r_state;
    logic [4:0]      r_s;
    logic [3:0]      r_n;
    logic [DBIT-1:0] r_sh;
    logic            r_p;
    logic            r_done;
    logic [DBIT-1:0] r_dout;
    logic            r_ferr;
    logic            r_perr;
    logic            r_busy;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // One more stage of the synchronised line for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_q <= 1'b1;
        end else begin
            r_rx_q <= w_rx_s;
        end
    end

    // Only a high-to-low transition starts a frame; a line held low (break)
    // never retriggers until it has been seen high again.
    assign w_fall = r_rx_q & ~w_rx_s;

    // Frame FSM with its tick/bit counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_sh    <= '0;
            r_p     <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_s     <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (s_tick) begin
                        if (r_s == MID_S) begin
                            // Mid start bit: still low means a real frame,
                            // high means the edge was a glitch.
                            if (!w_rx_s) begin
                                r_state <= DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_s     <= '0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                DATA: begin
                    if (s_tick) begin
                        if (r_s == LAST_OS) begin
                            // Sampling point is mid-bit; data arrives LSB first
                            r_sh <= {w_rx_s, r_sh[DBIT-1:1]};
                            r_s  <= '0;
                            if (r_n == LAST_BIT) begin
                                r_state <= PAR_EN ? PARITY : STOP;
                            end else begin
                                r_n <= r_n + 4'd1;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                PARITY: begin
                    if (s_tick) begin
                        if (r_s == LAST_OS) begin
                            r_p     <= w_rx_s;
                            r_s     <= '0;
                            r_state <= STOP;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                STOP: begin
                    if (s_tick) begin
                        if (r_s == STOP_LAST) begin
                            r_state <= IDLE;
                            r_s     <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_dout  <= r_sh;
                            r_ferr  <= ~w_rx_s;
                            r_perr  <= PAR_EN & parity_mismatch(9'(r_sh), r_p, PAR_ODD);
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_s     <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_done_tick = r_done;
    assign rx_dout      = r_dout;
    assign frame_err    = r_ferr;
    assign parity_err   = r_perr;
    assign busy         = r_busy;
    assign o_dbg_state  = r_state;

endmodule
